line_burst_adaptor: RTL

//  Sits directly downstream of the L1 cache datapath/control. Converts one 256-bit line

---
 rtl/line_adaptor_pkg.sv | 23 ++
 rtl/line_beat_buffer.sv | 34 +++
 rtl/line_burst_adaptor.sv | 139 +++++++++++++
 3 files changed

// File: rtl/line_adaptor_pkg.sv
// Shared constants and types for the cache-line to memory-burst adaptor.
package line_adaptor_pkg;

   localparam int BEAT_W = 64;
   localparam int BEATS  = 4;
   localparam int LINE_W = BEAT_W * BEATS;
   localparam int ADDR_W = 32;
   localparam int OFFS_W = $clog2(LINE_W / 8);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2,
      DONE     = 2'd3
   } adaptor_state_t;

   typedef logic [$clog2(BEATS)-1:0] beat_idx_t;

   function automatic logic is_last_beat(input beat_idx_t idx);
      return (idx == beat_idx_t'(BEATS - 1));
   endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// One-line storage: whole-line load for writes, per-beat fill for reads,
// and a beat-indexed read port that feeds the memory write data.
module line_beat_buffer
   import line_adaptor_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [LINE_W-1:0] load_line,
   input  logic              fill_en,
   input  beat_idx_t         fill_idx,
   input  logic [BEAT_W-1:0] fill_beat,
   input  beat_idx_t         rd_idx,
   output logic [LINE_W-1:0] line,
   output logic [BEAT_W-1:0] rd_beat
);

   logic [LINE_W-1:0] line_r;

   // line storage; reset clears any partially assembled line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_r <= {LINE_W{1'b0}};
      end else if (load_en) begin
         line_r <= load_line;
      end else if (fill_en) begin
         line_r[fill_idx*BEAT_W +: BEAT_W] <= fill_beat;
      end
   end

   assign line    = line_r;
   assign rd_beat = line_r[rd_idx*BEAT_W +: BEAT_W];

endmodule

// File: rtl/line_burst_adaptor.sv
// Converts one 256-bit cache line transaction into a 4-beat x 64-bit memory burst.
// Define LINE_ADAPTOR_ERR_EN to add the sticky protocol-error output err_o.
module line_burst_adaptor
   import line_adaptor_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
`ifdef LINE_ADAPTOR_ERR_EN
   output logic              err_o,
`endif
   input  logic [ADDR_W-1:0] address_i,
   input  logic [LINE_W-1:0] line_i,
   input  logic              read_i,
   input  logic              write_i,
   output logic [LINE_W-1:0] line_o,
   output logic              resp_o,
   output logic [ADDR_W-1:0] address_o,
   input  logic [BEAT_W-1:0] burst_i,
   output logic [BEAT_W-1:0] burst_o,
   output logic              read_o,
   output logic              write_o,
   input  logic              resp_i
);

   localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-OFFS_W){1'b1}}, {OFFS_W{1'b0}}};

   adaptor_state_t    state_r;
   adaptor_state_t    next_s;
   beat_idx_t         cnt_r;
   logic [ADDR_W-1:0] addr_r;
   logic              load_s;
   logic              fill_s;
   logic              in_burst_s;

   assign in_burst_s = (state_r == RD_BURST) || (state_r == WR_BURST);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // next-state logic; write takes priority over read when both are requested
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (write_i) begin
               next_s = WR_BURST;
            end else if (read_i) begin
               next_s = RD_BURST;
            end else begin
               next_s = IDLE;
            end
         end
         RD_BURST, WR_BURST: begin
            if (resp_i && is_last_beat(cnt_r)) begin
               next_s = DONE;
            end else begin
               next_s = state_r;
            end
         end
         DONE:    next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // Moore outputs and buffer controls decoded from the current state
   always_comb begin
      read_o  = 1'b0;
      write_o = 1'b0;
      resp_o  = 1'b0;
      load_s  = 1'b0;
      fill_s  = 1'b0;
      case (state_r)
         IDLE:     load_s = write_i;
         RD_BURST: begin
            read_o = 1'b1;
            fill_s = resp_i;
         end
         WR_BURST: write_o = 1'b1;
         DONE:     resp_o = 1'b1;
         default: begin
            read_o = 1'b0;
         end
      endcase
   end

   // beat counter and burst address latch; address only moves while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r  <= '0;
         addr_r <= {ADDR_W{1'b0}};
      end else begin
         if (in_burst_s && resp_i) begin
            cnt_r <= is_last_beat(cnt_r) ? beat_idx_t'(1'b0) : cnt_r + 1'b1;
         end
         if ((state_r == IDLE) && (write_i || read_i)) begin
            addr_r <= address_i & ADDR_MASK;
         end
      end
   end

   assign address_o = addr_r;

   line_beat_buffer u_buf (
      .clk       (clk),
      .rst       (rst),
      .load_en   (load_s),
      .load_line (line_i),
      .fill_en   (fill_s),
      .fill_idx  (cnt_r),
      .fill_beat (burst_i),
      .rd_idx    (cnt_r),
      .line      (line_o),
      .rd_beat   (burst_o)
   );

`ifdef LINE_ADAPTOR_ERR_EN
   logic err_r;

   // sticky protocol error: stray beat or conflicting request while idle, request dropped mid-burst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if ((state_r == IDLE) && (resp_i || (read_i && write_i))) begin
         err_r <= 1'b1;
      end else if (((state_r == RD_BURST) && !read_i) || ((state_r == WR_BURST) && !write_i)) begin
         err_r <= 1'b1;
      end
   end

   assign err_o = err_r;
`endif

endmodule
